instr_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 9-bit core. It owns the program counter
//  and steps each instruction through FETCH -> EXEC -> (MEMWAIT) phases.
//  It gates the Ctrl decode strobes (RegWrite, MemWrite) into one-cycle commit enables.
//  It resolves B/BLT/BEQ from ALU flags and handles Start/Stop/Done with the test bench.

---
 rtl/instr_sequencer_pkg.sv | 27 ++
 rtl/instr_sequencer_if.sv | 47 ++++
 rtl/instr_sequencer_branch_resolve.sv | 33 +++
 rtl/instr_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: none.
package instr_sequencer_pkg;

    // Phases an instruction steps through; IDLE/HALT are the parked states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        HALT    = 3'd4
    } seq_state_t;

    // Register-op field codes for the three branch flavours (Instruction[7:5]).
    localparam logic [2:0] kBEQ = 3'b101;
    localparam logic [2:0] kBLT = 3'b110;
    localparam logic [2:0] kB   = 3'b111;

    localparam int INSTR_W = 9;

    // Extract the register-op field of a machine word.
    function automatic logic [2:0] rop_of(input logic [INSTR_W-1:0] instr);
        return instr[7:5];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer and the core datapath/decoder.
// Latency: wires only.
// Backpressure: none; Start is a level request honoured only from IDLE/HALT.
// CycleCt exists only when CYCLE_COUNT_EN is defined.
interface instr_seq_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic [8:0]      Instruction;
    logic            Stop;
    logic            RegWrite;
    logic            MemWrite;
    logic            MemToReg;
    logic            Zero;
    logic            Less;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            IrLoad;
    logic            RegWriteEn;
    logic            MemWriteEn;
    logic            Busy;
    logic            Done;
`ifdef CYCLE_COUNT_EN
    logic [15:0]     CycleCt;
`endif

    // Sequencer side.
    modport master (
        input  Start, Instruction, Stop, RegWrite, MemWrite, MemToReg,
               Zero, Less, Target,
        output ProgCtr, IrLoad, RegWriteEn, MemWriteEn, Busy, Done
`ifdef CYCLE_COUNT_EN
        , output CycleCt
`endif
    );

    // Datapath / bench side.
    modport slave (
        output Start, Instruction, Stop, RegWrite, MemWrite, MemToReg,
               Zero, Less, Target,
        input  ProgCtr, IrLoad, RegWriteEn, MemWriteEn, Busy, Done
`ifdef CYCLE_COUNT_EN
        , input CycleCt
`endif
    );

endinterface

// File: rtl/instr_sequencer_branch_resolve.sv
// Decides whether the current instruction redirects the PC (B / BLT / BEQ).
// Latency: purely combinational.
// Backpressure: none.
module branch_resolve
    import instr_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               zero_i,
    input  logic               less_i,
    output logic               taken_o
);

    logic [2:0] rop;
    logic       unused_imm;

    assign rop        = rop_of(instr_i);
    // Low bits carry operands that do not influence the branch decision.
    assign unused_imm = ^instr_i[4:0];

    // Only register-type words (bit 8 clear) can branch.
    always_comb begin
        taken_o = 1'b0;
        if (!instr_i[8]) begin
            case (rop)
                kB:      taken_o = 1'b1;
                kBLT:    taken_o = less_i;
                kBEQ:    taken_o = zero_i;
                default: taken_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: owns the PC, steps FETCH->EXEC->(MEMWAIT), gates commits.
// Latency: ALU op 2 cycles, memory op 2+MEM_LAT cycles; Start->FETCH takes one edge.
// Backpressure: Start ignored while Busy; optional CycleCt output under CYCLE_COUNT_EN.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int          PC_W       = 10,
    parameter int          MEM_LAT    = 2,
    parameter int unsigned START_ADDR = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    instr_seq_if.master bus
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);

    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_upd;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irload_q, busy_q, done_q;
    logic             taken, mem_op, commit;

    branch_resolve u_branch (
        .instr_i (bus.Instruction),
        .zero_i  (bus.Zero),
        .less_i  (bus.Less),
        .taken_o (taken)
    );

    assign mem_op = bus.MemWrite | bus.MemToReg;
    assign pc_upd = taken ? bus.Target : pc_q + PC_W'(1);

    // Commit cycle is the last cycle of an instruction; a reset sampled in
    // that same cycle suppresses it so an aborted instruction never writes.
    assign commit = Reset &&
                    (((state_q == EXEC) && !bus.Stop && !(mem_op && (MEM_LAT > 0))) ||
                     ((state_q == MEMWAIT) && (cnt_q == '0)));

    // Next-state, PC and wait-counter decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.Start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                if (bus.Stop) begin
                    state_d = HALT;
                end else if (mem_op && (MEM_LAT > 0)) begin
                    state_d = MEMWAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_upd;
                end
            end
            MEMWAIT: begin
                if (cnt_q == '0) begin
                    state_d = FETCH;
                    pc_d    = pc_upd;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, PC, wait counter and state-derived flags, all registered.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= IDLE;
            pc_q     <= START_PC;
            cnt_q    <= '0;
            irload_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            irload_q <= (state_d == FETCH);
            busy_q   <= (state_d == FETCH) || (state_d == EXEC) || (state_d == MEMWAIT);
            done_q   <= (state_d == HALT);
        end
    end

    assign bus.ProgCtr    = pc_q;
    assign bus.IrLoad     = irload_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.RegWriteEn = commit & bus.RegWrite;
    assign bus.MemWriteEn = commit & bus.MemWrite;

`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    // Busy-cycle counter: cleared on a Start that leaves IDLE/HALT, saturates.
    always_comb begin
        cyc_d = cyc_q;
        if (((state_q == IDLE) || (state_q == HALT)) && bus.Start) begin
            cyc_d = '0;
        end else if (busy_q && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.CycleCt = cyc_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (PC_W=10, MEM_LAT=2, START_ADDR=0).
// Inputs change 1ns after a rising edge; outputs are checked 1ns later.
// Define CYCLE_COUNT_EN to also exercise CycleCt.
module tb_instr_sequencer;

    localparam int PC_W = 10;

    logic Clk;
    logic Reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    instr_seq_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(
        .PC_W       (PC_W),
        .MEM_LAT    (2),
        .START_ADDR (0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] instr, input logic rw, input logic mw,
                          input logic mr, input logic stp, input logic z, input logic l,
                          input logic [PC_W-1:0] tgt);
        bus.Instruction = instr;
        bus.RegWrite    = rw;
        bus.MemWrite    = mw;
        bus.MemToReg    = mr;
        bus.Stop        = stp;
        bus.Zero        = z;
        bus.Less        = l;
        bus.Target      = tgt;
        #1;
    endtask

    // Called in FETCH: one ALU op (RegWrite) through EXEC back to FETCH.
    task automatic alu_op(input logic [PC_W-1:0] exp_pc, input string tag);
        set_in(9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk({tag, "_fetch_rwe"}, 32'(bus.RegWriteEn), 32'd0);
        tick();
        chk({tag, "_exec_rwe"}, 32'(bus.RegWriteEn), 32'd1);
        chk({tag, "_exec_irl"}, 32'(bus.IrLoad), 32'd0);
        tick();
        chk({tag, "_pc"}, 32'(bus.ProgCtr), 32'(exp_pc));
        chk({tag, "_irl"}, 32'(bus.IrLoad), 32'd1);
    endtask

    // Called in FETCH: one branch-type word through EXEC back to FETCH.
    task automatic br_op(input logic [8:0] instr, input logic z, input logic l,
                         input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] exp_pc,
                         input string tag);
        set_in(instr, 1'b0, 1'b0, 1'b0, 1'b0, z, l, tgt);
        tick();
        tick();
        chk(tag, 32'(bus.ProgCtr), 32'(exp_pc));
    endtask

    initial begin
        Reset     = 1'b0;
        bus.Start = 1'b0;
        set_in(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        tick();
        chk("rst_pc",   32'(bus.ProgCtr),    32'd0);
        chk("rst_busy", 32'(bus.Busy),       32'd0);
        chk("rst_done", 32'(bus.Done),       32'd0);
        chk("rst_irl",  32'(bus.IrLoad),     32'd0);
        chk("rst_rwe",  32'(bus.RegWriteEn), 32'd0);
        chk("rst_mwe",  32'(bus.MemWriteEn), 32'd0);

        Reset = 1'b1;
        tick();
        chk("idle_hold", 32'(bus.Busy), 32'd0);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        chk("start_irl",  32'(bus.IrLoad),  32'd1);
        chk("start_busy", 32'(bus.Busy),    32'd1);
        chk("start_done", 32'(bus.Done),    32'd0);
        chk("start_pc",   32'(bus.ProgCtr), 32'd0);

        alu_op(10'd1, "alu1");
        alu_op(10'd2, "alu2");
        alu_op(10'd3, "alu3");
        bus.Start = 1'b1;
        alu_op(10'd4, "alu4_startbusy");
        alu_op(10'd5, "alu5_startbusy");
        bus.Start = 1'b0;

        // LW at PC=5: EXEC, MEMWAIT x2, commit on the last MEMWAIT cycle.
        set_in(9'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        chk("lw_exec_rwe", 32'(bus.RegWriteEn), 32'd0);
        tick();
        chk("lw_mw1_rwe",  32'(bus.RegWriteEn), 32'd0);
        chk("lw_mw1_busy", 32'(bus.Busy),       32'd1);
        chk("lw_mw1_irl",  32'(bus.IrLoad),     32'd0);
        chk("lw_mw1_pc",   32'(bus.ProgCtr),    32'd5);
        tick();
        chk("lw_mw2_rwe",  32'(bus.RegWriteEn), 32'd1);
        chk("lw_mw2_mwe",  32'(bus.MemWriteEn), 32'd0);
        tick();
        chk("lw_pc",       32'(bus.ProgCtr),    32'd6);
        chk("lw_fetch_rwe", 32'(bus.RegWriteEn), 32'd0);

        // SW at PC=6.
        set_in(9'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        chk("sw_exec_mwe", 32'(bus.MemWriteEn), 32'd0);
        tick();
        chk("sw_mw1_mwe",  32'(bus.MemWriteEn), 32'd0);
        tick();
        chk("sw_mw2_mwe",  32'(bus.MemWriteEn), 32'd1);
        chk("sw_mw2_rwe",  32'(bus.RegWriteEn), 32'd0);
        tick();
        chk("sw_pc",       32'(bus.ProgCtr),    32'd7);

        // Branches, Target = 0x40.
        br_op(9'h0A0, 1'b1, 1'b0, 10'h040, 10'h040, "beq_taken");
        br_op(9'h0C0, 1'b0, 1'b0, 10'h040, 10'h041, "blt_not_taken");
        br_op(9'h0E0, 1'b0, 1'b0, 10'h040, 10'h040, "b_always");
        br_op(9'h0C0, 1'b0, 1'b1, 10'h040, 10'h040, "blt_taken");
        br_op(9'h0A0, 1'b0, 1'b1, 10'h040, 10'h041, "beq_not_taken");
        br_op(9'h1E0, 1'b1, 1'b1, 10'h040, 10'h042, "bit8_no_branch");

        // PC wrap at all-ones.
        br_op(9'h0E0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, "b_to_3ff");
        alu_op(10'h000, "wrap");

        // STOP at PC=9: no strobes even with decode strobes asserted.
        br_op(9'h0E0, 1'b0, 1'b0, 10'd9, 10'd9, "b_to_9");
        set_in(9'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        tick();
        chk("stop_exec_rwe", 32'(bus.RegWriteEn), 32'd0);
        chk("stop_exec_mwe", 32'(bus.MemWriteEn), 32'd0);
        tick();
        chk("halt_done", 32'(bus.Done),       32'd1);
        chk("halt_busy", 32'(bus.Busy),       32'd0);
        chk("halt_pc",   32'(bus.ProgCtr),    32'd9);
        chk("halt_rwe",  32'(bus.RegWriteEn), 32'd0);
        tick();
        chk("halt_pc2",  32'(bus.ProgCtr),    32'd9);
        chk("halt_done2", 32'(bus.Done),      32'd1);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        set_in(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("restart_pc",   32'(bus.ProgCtr), 32'd0);
        chk("restart_done", 32'(bus.Done),    32'd0);
        chk("restart_busy", 32'(bus.Busy),    32'd1);
        chk("restart_irl",  32'(bus.IrLoad),  32'd1);

`ifdef CYCLE_COUNT_EN
        chk("cyc_clear", 32'(bus.CycleCt), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            alu_op(PC_W'(i), "cyc_alu");
        end
        chk("cyc_20", 32'(bus.CycleCt), 32'd20);
`endif

        // Reset during the final MEMWAIT cycle of a store aborts the commit.
        set_in(9'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("abort_mwe", 32'(bus.MemWriteEn), 32'd0);
        tick();
        chk("abort_busy", 32'(bus.Busy),       32'd0);
        chk("abort_done", 32'(bus.Done),       32'd0);
        chk("abort_pc",   32'(bus.ProgCtr),    32'd0);
        chk("abort_mwe2", 32'(bus.MemWriteEn), 32'd0);
        Reset = 1'b1;
        set_in(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        chk("abort_idle", 32'(bus.Busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
